// File: rtl/boot_link_pkg.sv
// Shared constants, state encoding and frame sizing for the UART bootloader link.
// Build option: BOOT_INIT_CHECKSUM_EN appends an XOR check byte to each frame and reply.
package boot_link_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

`ifdef BOOT_INIT_CHECKSUM_EN
  localparam int REPLY_BYTES = 5;
`else
  localparam int REPLY_BYTES = 4;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_RECV,
    ST_DONE
  } state_e;

  // Number of bytes the initiator transmits for one request.
  function automatic logic [3:0] frame_len(input logic is_write);
    logic [3:0] n;
    n = is_write ? 4'd8 : 4'd4;
`ifdef BOOT_INIT_CHECKSUM_EN
    n = n + 4'd1;
`endif
    return n;
  endfunction

endpackage

// File: rtl/boot_uart_tx_byte.sv
// 8N1 byte serialiser with its own baud counter; a start on the done cycle chains bytes gap-free.
module boot_uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       done_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic             busy_q, busy_d;
  logic [9:0]       shreg_q, shreg_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_o = busy_q && (bit_q == 4'd9) && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign tx_o   = busy_q ? shreg_q[0] : 1'b1;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d  = busy_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    if (busy_q) begin
      if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
        end else begin
          bit_d   = bit_q + 4'd1;
          shreg_d = {1'b1, shreg_q[9:1]};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (start_i && (!busy_q || done_o)) begin
      busy_d  = 1'b1;
      shreg_d = {1'b1, data_i, 1'b0};
      bit_d   = 4'd0;
      cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      shreg_q <= '1;
      bit_q   <= 4'd0;
      cnt_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/boot_uart_initiator.sv
// Host-side bootloader initiator: frames word requests onto tx, collects read replies from rx.
// Build option: BOOT_INIT_CHECKSUM_EN adds the XOR check byte on both directions.
module boot_uart_initiator
  import boot_link_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  tx,
  input  logic                  rx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int TO_W         = $clog2(TO_CYCLES + 1);

  state_e                state_q, state_d;
  logic                  write_q, write_d;
  logic [15:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            idx_q, idx_d;
  logic                  kick_q, kick_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, acc_q, acc_d;
  logic                  rx_s1_q, rx_s2_q, rx_s3_q;
  logic                  rx_act_q, rx_act_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [7:0]            rx_sh_q, rx_sh_d;
  logic [2:0]            rx_k_q, rx_k_d;
  logic [TO_W-1:0]       to_q, to_d;

  logic       tx_start, tx_done, rx_fall;
  logic [7:0] tx_byte;
  logic [3:0] last_idx, send_idx;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_err   = (state_q == ST_DONE) && err_q;
  assign rsp_rdata = rdata_q;
  assign rx_fall   = rx_s3_q && !rx_s2_q;

`ifdef BOOT_INIT_CHECKSUM_EN
  logic [7:0] frame_csum;
  assign frame_csum = SYNC_BYTE ^ (write_q ? CMD_WRITE : CMD_READ) ^ addr_q[15:8] ^ addr_q[7:0]
                    ^ (write_q ? (wdata_q[7:0] ^ wdata_q[15:8] ^ wdata_q[23:16] ^ wdata_q[31:24])
                               : 8'h00);
`endif

  // Byte to launch now: index 0 on the kick cycle, otherwise the one after the byte finishing.
  always_comb begin
    last_idx = frame_len(write_q) - 4'd1;
    send_idx = kick_q ? 4'd0 : idx_q + 4'd1;
    tx_byte  = 8'h00;
    case (send_idx)
      4'd0:    tx_byte = SYNC_BYTE;
      4'd1:    tx_byte = write_q ? CMD_WRITE : CMD_READ;
      4'd2:    tx_byte = addr_q[15:8];
      4'd3:    tx_byte = addr_q[7:0];
      4'd4:    tx_byte = wdata_q[7:0];
      4'd5:    tx_byte = wdata_q[15:8];
      4'd6:    tx_byte = wdata_q[23:16];
      4'd7:    tx_byte = wdata_q[31:24];
      default: tx_byte = 8'h00;
    endcase
`ifdef BOOT_INIT_CHECKSUM_EN
    if (send_idx == last_idx) tx_byte = frame_csum;
`endif
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    idx_d    = idx_q;
    kick_d   = 1'b0;
    err_d    = err_q;
    rdata_d  = rdata_q;
    acc_d    = acc_q;
    rx_act_d = rx_act_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_k_d   = rx_k_q;
    to_d     = to_q;
    tx_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = 16'(req_addr);
          wdata_d = req_wdata;
          kick_d  = 1'b1;
          err_d   = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (kick_q || (tx_done && (idx_q != last_idx))) begin
          tx_start = 1'b1;
          idx_d    = send_idx;
        end else if (tx_done) begin
          if (write_q) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_RECV;
            to_d     = TO_W'(TO_CYCLES);
            rx_act_d = 1'b0;
            rx_k_d   = 3'd0;
          end
        end
      end
      ST_RECV: begin
        if (!rx_act_q) begin
          if (to_q == '0) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            to_d = to_q - 1'b1;
            if (rx_fall) begin
              rx_act_d = 1'b1;
              rx_cnt_d = CNT_W'(HALF_BIT - 1);
              rx_bit_d = 4'd0;
            end
          end
        end else if (rx_cnt_q != '0) begin
          rx_cnt_d = rx_cnt_q - 1'b1;
        end else begin
          rx_cnt_d = CNT_W'(CLKS_PER_BIT - 1);
          rx_bit_d = rx_bit_q + 4'd1;
          if (rx_bit_q == 4'd0) begin
            if (rx_s2_q) rx_act_d = 1'b0;  // start bit gone high: glitch, rearm
          end else if (rx_bit_q != 4'd9) begin
            rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
          end else begin
            rx_act_d = 1'b0;
            to_d     = TO_W'(TO_CYCLES);
            rx_k_d   = rx_k_q + 3'd1;
            if (!rx_s2_q) begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end else if (rx_k_q == 3'(REPLY_BYTES - 1)) begin
              state_d = ST_DONE;
`ifdef BOOT_INIT_CHECKSUM_EN
              if (rx_sh_q == (acc_q[7:0] ^ acc_q[15:8] ^ acc_q[23:16] ^ acc_q[31:24]))
                rdata_d = acc_q;
              else
                err_d = 1'b1;
`else
              rdata_d = {rx_sh_q, acc_q[DATA_WIDTH-1:8]};
`endif
            end else begin
              acc_d = {rx_sh_q, acc_q[DATA_WIDTH-1:8]};
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  boot_uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(tx_start),
    .data_i (tx_byte),
    .tx_o   (tx),
    .done_o (tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idx_q    <= 4'd0;
      kick_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      acc_q    <= '0;
      rx_s1_q  <= 1'b1;
      rx_s2_q  <= 1'b1;
      rx_s3_q  <= 1'b1;
      rx_act_q <= 1'b0;
      rx_cnt_q <= '0;
      rx_bit_q <= 4'd0;
      rx_sh_q  <= 8'h00;
      rx_k_q   <= 3'd0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      kick_q   <= kick_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      acc_q    <= acc_d;
      rx_s1_q  <= rx;
      rx_s2_q  <= rx_s1_q;
      rx_s3_q  <= rx_s2_q;
      rx_act_q <= rx_act_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      rx_k_q   <= rx_k_d;
      to_q     <= to_d;
    end
  end

endmodule

// File: tb/tb_boot_uart_initiator.sv
// Directed bench for boot_uart_initiator at 10 clocks per bit; honours BOOT_INIT_CHECKSUM_EN.
module tb_boot_uart_initiator;

  localparam int CPB = 10;
`ifdef BOOT_INIT_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rx = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, busy, tx;
  logic [31:0] rsp_rdata;

  boot_uart_initiator #(
    .CLK_FREQ    (1_000_000),
    .BAUD_RATE   (100_000),
    .ADDR_WIDTH  (10),
    .DATA_WIDTH  (32),
    .TIMEOUT_BITS(64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .tx       (tx),
    .rx       (rx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Serial decoder on tx: detect start at negedge, sample each bit mid-period.
  logic [7:0] tx_q[$];
  int first_start = 0;
  int last_stop = 0;
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        if (tx_q.size() == 0) first_start = cyc;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        last_stop = cyc;
        tx_q.push_back(b);
      end
    end
  end

  int          rsp_count = 0;
  int          rsp_time = 0;
  int          ready_bad = 0;
  logic        cap_err = 1'b0;
  logic [31:0] cap_rdata = '0;
  initial begin : rsp_mon
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && req_ready === 1'b1) ready_bad++;
      if (rsp_valid === 1'b1) begin
        rsp_count++;
        rsp_time  = cyc;
        cap_err   = rsp_err;
        cap_rdata = rsp_rdata;
      end
    end
  end

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        reply;
    logic [31:0] rbytes;     // reply data bytes, LSB sent first
    logic [7:0]  rchk;       // reply check byte (checksum build only)
    logic [63:0] exp_tx;     // byte i of the frame at bits [8i+7:8i]
    logic [7:0]  exp_csum;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          lat_lo;     // rsp latency after end of last stop bit; -1 = not checked
    int          lat_hi;
  } vec_t;

  task automatic send_rx_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  int n0;

  task automatic issue(input string nm, input vec_t v);
    tx_q.delete();
    n0 = rsp_count;
    ready_bad = 0;
    @(negedge clk);
    check({nm, "_ready_idle"}, req_ready, 1);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    check({nm, "_busy_after_hs"}, busy, 1);
  endtask

  task automatic wait_tx(input string nm, input int n);
    int guard;
    guard = 0;
    while (tx_q.size() < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check({nm, "_tx_count"}, tx_q.size(), n);
  endtask

  task automatic finish_txn(input string nm, input vec_t v);
    int          guard, n_base, lat;
    logic [63:0] got;
    logic [63:0] csum_got;
    n_base = v.wr ? 8 : 4;
    guard = 0;
    while (rsp_count == n0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check({nm, "_rsp_pulses"}, rsp_count - n0, 1);
    got = '0;
    for (int i = 0; i < n_base && i < tx_q.size(); i++) got[8*i+:8] = tx_q[i];
    check({nm, "_frame"}, got, v.exp_tx & ((n_base == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF));
`ifdef BOOT_INIT_CHECKSUM_EN
    csum_got = (tx_q.size() > n_base) ? {56'd0, tx_q[n_base]} : 64'hFFFF_FFFF_FFFF_FFFF;
    check({nm, "_csum"}, csum_got, {56'd0, v.exp_csum});
`else
    csum_got = '0;
`endif
    check({nm, "_frame_span"}, last_stop + 6 - first_start, 100 * (n_base + CS));
    check({nm, "_err"}, cap_err, v.exp_err);
    check({nm, "_rdata"}, cap_rdata, v.exp_rdata);
    check({nm, "_ready_low_busy"}, ready_bad, 0);
    check({nm, "_idle_after"}, {busy, req_ready}, 2'b01);
    if (v.lat_lo >= 0) begin
      lat = rsp_time - (last_stop + 6);
      if (lat < v.lat_lo || lat > v.lat_hi) check({nm, "_latency"}, lat, v.lat_lo);
      else check({nm, "_latency"}, 1, 1 + csum_got[63]);
    end
  endtask

  task automatic run_txn(input string nm, input vec_t v);
    issue(nm, v);
    wait_tx(nm, (v.wr ? 8 : 4) + CS);
    if (v.reply) begin
      repeat (20) @(negedge clk);
      for (int k = 0; k < 4; k++) send_rx_byte(v.rbytes[8*k+:8]);
`ifdef BOOT_INIT_CHECKSUM_EN
      send_rx_byte(v.rchk);
`endif
    end
    finish_txn(nm, v);
  endtask

  vec_t tbl[6];
  vec_t gv;
  vec_t rv;
  vec_t pv;
  int   nv;

  initial begin
    // wr, addr, wdata, reply, rbytes, rchk, exp_tx, exp_csum, exp_err, exp_rdata, lat_lo, lat_hi
    tbl[0] = '{1'b1, 10'h003, 32'hDEADBEEF, 1'b0, 32'h0, 8'h00,
               64'hDEADBEEF_0300_57A5, 8'hD3, 1'b0, 32'h0000_0000, 0, 0};
    tbl[1] = '{1'b0, 10'h3FF, 32'h0, 1'b1, 32'h12345678, 8'h08,
               64'h0000_0000_FF03_52A5, 8'h0B, 1'b0, 32'h1234_5678, -1, -1};
    tbl[2] = '{1'b0, 10'h155, 32'h0, 1'b0, 32'h0, 8'h00,
               64'h0000_0000_5501_52A5, 8'hA3, 1'b1, 32'h1234_5678, 640, 642};
    tbl[3] = '{1'b1, 10'h100, 32'h01020304, 1'b0, 32'h0, 8'h00,
               64'h01020304_0001_57A5, 8'hF7, 1'b0, 32'h1234_5678, 0, 0};
    tbl[4] = '{1'b0, 10'h001, 32'h0, 1'b1, 32'h04030201, 8'h05,
               64'h0000_0000_0100_52A5, 8'hF6, 1'b1, 32'h1234_5678, -1, -1};
    tbl[5] = '{1'b0, 10'h001, 32'h0, 1'b1, 32'h04030201, 8'h04,
               64'h0000_0000_0100_52A5, 8'hF6, 1'b0, 32'h0403_0201, -1, -1};
`ifdef BOOT_INIT_CHECKSUM_EN
    nv = 6;
`else
    nv = 4;
`endif
    gv = '{1'b0, 10'h020, 32'h0, 1'b1, 32'hDDCCBBAA, 8'h00,
           64'h0000_0000_2000_52A5, 8'hD7, 1'b0, 32'hDDCC_BBAA, -1, -1};
    rv = '{1'b1, 10'h0F0, 32'h11223344, 1'b0, 32'h0, 8'h00,
           64'h0, 8'h00, 1'b0, 32'h0, -1, -1};
    pv = '{1'b1, 10'h001, 32'h00000000, 1'b0, 32'h0, 8'h00,
           64'h00000000_0100_57A5, 8'hF3, 1'b0, 32'h0000_0000, 0, 0};

    // Reset values, observed while rst_n is held low.
    #12;
    check("rst_tx", tx, 1);
    check("rst_req_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < nv; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

    // Single-cycle low glitch on rx while waiting for the reply must be rejected.
    issue("glitch", gv);
    wait_tx("glitch", 4 + CS);
    repeat (20) @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    for (int k = 0; k < 4; k++) send_rx_byte(gv.rbytes[8*k+:8]);
`ifdef BOOT_INIT_CHECKSUM_EN
    send_rx_byte(gv.rchk);
`endif
    finish_txn("glitch", gv);

    // Reset in the middle of byte 2 (address high byte 0x00, so the line is low).
    issue("rstmid", rv);
    wait_tx("rstmid", 2);
    repeat (30) @(negedge clk);
    check("rstmid_tx_low_before", tx, 0);
    #2 rst_n = 1'b0;
    #1 check("rstmid_tx_async_high", tx, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_ready_after", req_ready, 1);
    check("rstmid_busy_after", busy, 0);
    repeat (150) @(negedge clk);
    check("rstmid_no_rsp", rsp_count - n0, 0);
    check("rstmid_tx_idle", tx, 1);

    run_txn("post_rst", pv);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
